// File: rtl/excess3_pkg.sv
// Shared constants and types for the Excess-3 to BCD stream packer.
// Imported by the digit decoder and the top level.
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN    = 4'h3;
  localparam logic [3:0] E3_MAX    = 4'hC;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational Excess-3 digit decoder.
// Invalid codes decode to zero and raise the invalid flag.
module excess3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       invalid
);

  // Range check then subtract the Excess-3 bias
  always_comb begin
    invalid = (code < E3_MIN) || (code > E3_MAX);
    bcd     = invalid ? 4'h0 : code - E3_OFFSET;
  end

endmodule

// File: rtl/excess3_to_bcd_stream.sv
// Packs a stream of Excess-3 digits into NUM_DIGITS-wide BCD words
// with a one-deep output register and valid/ready on both sides.
module excess3_to_bcd_stream
  import excess3_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [3:0]              in_digit,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic                    out_err,
  input  logic                    out_ready
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-5:0]    acc;
  logic            err_acc;
  logic [3:0]      dig;
  logic            inv;
  logic            in_fire;
  logic            word_done;
  logic [W-1:0]    word;

  excess3_digit_decode u_dec (
    .code    (in_digit),
    .bcd     (dig),
    .invalid (inv)
  );

  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign word_done = in_fire && (state == COLLECT) && (cnt == LAST);
  assign word      = {acc, dig};

  // Collect digits; clear the partial word once it is complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      err_acc <= 1'b0;
    end else if (in_fire) begin
      if (word_done) begin
        state   <= IDLE;
        cnt     <= '0;
        acc     <= '0;
        err_acc <= 1'b0;
      end else begin
        state   <= COLLECT;
        cnt     <= cnt + CW'(1);
        acc     <= word[W-5:0];
        err_acc <= err_acc | inv;
      end
    end
  end

  // Output register: load on completion, drop valid on transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_err   <= 1'b0;
    end else if (word_done) begin
      out_valid <= 1'b1;
      out_bcd   <= word;
      out_err   <= err_acc | inv;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd_stream.sv
// Self-checking bench for excess3_to_bcd_stream (NUM_DIGITS=4).
// Directed scenarios plus a randomized run against a queue model.
module tb_excess3_to_bcd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_bcd;
  logic        out_err;
  logic        out_ready;

  int pass_cnt = 0;
  int total    = 0;

  excess3_to_bcd_stream #(.NUM_DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_digit  (in_digit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int e3_val(input int code);
    if (code >= 3 && code <= 12) return code - 3;
    return 0;
  endfunction

  function automatic bit e3_bad(input int code);
    return !(code >= 3 && code <= 12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_digit = d;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_digit = 4'h0; out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_bcd !== 16'h0 || out_err !== 1'b0)
      $display("FAIL reset_outputs: got v=%b bcd=%h e=%b need 0/0000/0",
               out_valid, out_bcd, out_err);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] ds [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ds[i]);
      if (i < 3) begin
        total++;
        if (out_valid !== 1'b0)
          $display("FAIL basic_early_valid: digit %0d got %b need 0", i, out_valid);
        else pass_cnt++;
      end
    end
    total++;
    if (out_valid !== 1'b1 || out_bcd !== 16'h1234 || out_err !== 1'b0)
      $display("FAIL basic_word: got v=%b bcd=%h e=%b need 1/1234/0",
               out_valid, out_bcd, out_err);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_one_cycle: got v=%b need 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_error();
    out_ready = 1'b1;
    send(4'h4); send(4'hF); send(4'h6); send(4'h7);
    total++;
    if (out_valid !== 1'b1 || out_bcd !== 16'h1034 || out_err !== 1'b1)
      $display("FAIL err_word: got v=%b bcd=%h e=%b need 1/1034/1",
               out_valid, out_bcd, out_err);
    else pass_cnt++;
    send(4'h3); send(4'h3); send(4'h3); send(4'hC);
    total++;
    if (out_valid !== 1'b1 || out_bcd !== 16'h0009 || out_err !== 1'b0)
      $display("FAIL err_cleared: got v=%b bcd=%h e=%b need 1/0009/0",
               out_valid, out_bcd, out_err);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'h4); send(4'h5); send(4'h6); send(4'h7);
    in_valid = 1'b1;
    in_digit = 4'h9;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_bcd !== 16'h1234 || in_ready !== 1'b0)
        $display("FAIL bp_hold: cyc %0d got v=%b bcd=%h rdy=%b need 1/1234/0",
                 i, out_valid, out_bcd, in_ready);
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_release_ready: got %b need 1", in_ready);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_transfer: got v=%b need 0", out_valid);
    else pass_cnt++;
    send(4'h3); send(4'h3); send(4'h4); send(4'h3);
    total++;
    if (out_bcd !== 16'h0010 || out_valid !== 1'b1)
      $display("FAIL bp_no_side_effect: got v=%b bcd=%h need 1/0010",
               out_valid, out_bcd);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [3:0] ds [8] = '{4'hC, 4'hB, 4'hA, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_digit = ds[i];
      #1;
      total++;
      if (in_ready !== 1'b1)
        $display("FAIL stream_ready: digit %0d got %b need 1", i, in_ready);
      else pass_cnt++;
      tick();
      total++;
      if (i == 3 || i == 7) begin
        if (out_valid !== 1'b1 ||
            out_bcd !== ((i == 3) ? 16'h9876 : 16'h5432))
          $display("FAIL stream_word: digit %0d got v=%b bcd=%h", i, out_valid, out_bcd);
        else pass_cnt++;
      end else begin
        if (out_valid !== 1'b0)
          $display("FAIL stream_gap: digit %0d got v=%b need 0", i, out_valid);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(4'h4); send(4'h5);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_bcd !== 16'h0)
      $display("FAIL rstmid_during: got v=%b bcd=%h need 0/0000", out_valid, out_bcd);
    else pass_cnt++;
    #2 rst = 1'b0;
    tick();
    send(4'hC); send(4'hC); send(4'h3); send(4'h3);
    total++;
    if (out_valid !== 1'b1 || out_bcd !== 16'h9900 || out_err !== 1'b0)
      $display("FAIL rstmid_word: got v=%b bcd=%h e=%b need 1/9900/0",
               out_valid, out_bcd, out_err);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_exhaustive();
    logic [15:0] exp_w;
    logic        exp_e;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      send(4'(c)); send(4'h3); send(4'h3); send(4'h3);
      exp_w = 16'(e3_val(c) * 4096);
      exp_e = e3_bad(c);
      total++;
      if (out_valid !== 1'b1 || out_bcd !== exp_w || out_err !== exp_e)
        $display("FAIL exh_code_%0h: got v=%b bcd=%h e=%b need 1/%h/%b",
                 c, out_valid, out_bcd, out_err, exp_w, exp_e);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [16:0] expq [$];
    logic [16:0] exp_item;
    int n = 0;
    int w = 0;
    bit e = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_digit  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      total++;
      if (in_ready !== (!out_valid || out_ready))
        $display("FAIL rand_in_ready: cyc %0d got %b", cyc, in_ready);
      else pass_cnt++;
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          $display("FAIL rand_unexpected_word: cyc %0d got %h", cyc, out_bcd);
        end else begin
          exp_item = expq.pop_front();
          if ({out_err, out_bcd} !== exp_item)
            $display("FAIL rand_word: cyc %0d got e=%b bcd=%h need e=%b bcd=%h",
                     cyc, out_err, out_bcd, exp_item[16], exp_item[15:0]);
          else pass_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        w = w * 16 + e3_val(int'(in_digit));
        e = e | e3_bad(int'(in_digit));
        n++;
        if (n == 4) begin
          expq.push_back({e, 16'(w)});
          n = 0; w = 0; e = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      if (out_valid) begin
        total++;
        if (expq.size() == 0) begin
          $display("FAIL rand_drain_extra: got %h", out_bcd);
        end else begin
          exp_item = expq.pop_front();
          if ({out_err, out_bcd} !== exp_item)
            $display("FAIL rand_drain_word: got e=%b bcd=%h need e=%b bcd=%h",
                     out_err, out_bcd, exp_item[16], exp_item[15:0]);
          else pass_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (expq.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rand_drain_end: pending=%0d v=%b need 0/0", expq.size(), out_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_exhaustive();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
